// File: rtl/truth_table_checker_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_checker_pkg
//   Shared types and sizing helpers for the truth-table self-test engine.
//   - state_t         : FSM state of the checker (IDLE, APPLY, DONE)
//   - num_vec()       : number of input vectors for an N-input block (1 << N)
//   - hold_cnt_width(): width of the per-vector hold counter
// -----------------------------------------------------------------------------
package truth_table_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Exhaustive stimulus covers every combination of the n inputs.
  function automatic int num_vec(input int n);
    return 1 << n;
  endfunction

  // Wide enough to hold any value in 0..hold.
  function automatic int hold_cnt_width(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// -----------------------------------------------------------------------------
// truth_table_checker_if
//   Groups the control, stimulus and result signals of truth_table_checker.
//   Ports (from the checker's point of view):
//     start            in   1-cycle run request (honoured only in IDLE/DONE)
//     dut_f            in   response of the block under test to vec
//     vec              out  stimulus {a,b,c,d}, a is the MSB
//     busy             out  run in progress
//     done             out  run finished, held until restart or reset
//     pass             out  done with zero mismatches
//     err_count        out  number of mismatching vectors
//     first_fail_idx   out  index of the first mismatching vector
//     first_fail_valid out  first_fail_idx is meaningful
//   Modports:
//     master : environment side (issues start, returns dut_f)
//     slave  : checker side
// -----------------------------------------------------------------------------
interface truth_table_checker_if #(
  parameter int N_IN = 4
);

  logic            start;
  logic            dut_f;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_fail_idx;
  logic            first_fail_valid;

  modport master (
    output start,
    output dut_f,
    input  vec,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail_idx,
    input  first_fail_valid
  );

  modport slave (
    input  start,
    input  dut_f,
    output vec,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail_idx,
    output first_fail_valid
  );

endinterface

// File: rtl/truth_table_checker_hold_timer.sv
// -----------------------------------------------------------------------------
// truth_table_checker_hold_timer
//   Counts the clocks a stimulus vector has been held and flags the last one.
//   The counter wraps to zero by itself after the last clock so the next vector
//   starts a fresh hold period without any help from the FSM.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     clear  in   force the counter to zero (start of a run)
//     en     in   count this clock (vector is being applied)
//     last   out  counter is at HOLD_CYCLES-1: this edge samples the response
// -----------------------------------------------------------------------------
module truth_table_checker_hold_timer
  import truth_table_checker_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  localparam int            W        = hold_cnt_width(HOLD_CYCLES);
  localparam logic [W-1:0]  LAST_CNT = W'(HOLD_CYCLES - 1);

  logic [W-1:0] hold_cnt;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the counter is reset because its value decides when the response is
  // sampled; an unknown start value would shift the first compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (clear) begin
      hold_cnt <= '0;
    end else if (en) begin
      hold_cnt <= last ? '0 : hold_cnt + W'(1);
    end
  end

  assign last = (hold_cnt == LAST_CNT);

endmodule

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//   On-board self-test engine for an N_IN-input, single-output combinational
//   block. A run walks every input vector in ascending order, holds each one
//   for HOLD_CYCLES clocks, samples the block's response on the last held
//   clock and compares it with the GOLDEN truth table (bit i = expected f for
//   vector i). It reports the mismatch count, the first failing vector and an
//   overall pass flag.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset, clears all results
//     bus    slave side of truth_table_checker_if (start, dut_f in; vec,
//            busy, done, pass, err_count, first_fail_idx, first_fail_valid out)
// -----------------------------------------------------------------------------
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter int                        N_IN        = 4,
  parameter int                        HOLD_CYCLES = 20,
  parameter logic [num_vec(N_IN)-1:0]  GOLDEN      = 16'hA5C3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_checker_if.slave bus
);

  localparam int              NUM_VEC  = num_vec(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NUM_VEC - 1);

  state_t          state;
  logic [N_IN-1:0] vec_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_count_q;
  logic [N_IN-1:0] first_fail_idx_q;
  logic            first_fail_valid_q;

  logic            start_run;
  logic            hold_last;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // A request is only honoured when no run is in progress.
  assign start_run = bus.start && (state != APPLY);

  truth_table_checker_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_run),
    .en    (state == APPLY),
    .last  (hold_last)
  );

  // err_next is the count including the vector being sampled this edge, so
  // the pass flag taken on the final vector already reflects its result.
  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    mismatch = 1'b0;
    err_next = err_count_q;
    mismatch = (bus.dut_f != GOLDEN[vec_q]);
    err_next = err_count_q + (N_IN+1)'(mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      vec_q              <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      err_count_q        <= '0;
      first_fail_idx_q   <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // Results of a previous run stay visible until a new start.
          if (bus.start) begin
            state              <= APPLY;
            vec_q              <= '0;
            busy_q             <= 1'b1;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            err_count_q        <= '0;
            first_fail_idx_q   <= '0;
            first_fail_valid_q <= 1'b0;
          end
        end

        APPLY: begin
          if (hold_last) begin
            if (mismatch) begin
              err_count_q <= err_next;
              if (!first_fail_valid_q) begin
                first_fail_idx_q   <= vec_q;
                first_fail_valid_q <= 1'b1;
              end
            end
            if (vec_q == LAST_VEC) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_next == '0);
            end else begin
              vec_q <= vec_q + N_IN'(1);
            end
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vec              = vec_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_count_q;
  assign bus.first_fail_idx   = first_fail_idx_q;
  assign bus.first_fail_valid = first_fail_valid_q;

endmodule
